// File: rtl/uart_alu_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_alu_sequencer: gathers A, B, opcode from UART RX, runs the ALU,   |
// | hands the result to UART TX; drops partial commands on tick timeout.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module uart_alu_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int OP_WIDTH      = 6,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  TICK,
  input  logic                  rx_done,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  tx_done,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [OP_WIDTH-1:0]   opcode,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam logic [2:0] S_WAIT_A  = 3'd0;
  localparam logic [2:0] S_WAIT_B  = 3'd1;
  localparam logic [2:0] S_WAIT_OP = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;

  // A zero limit still needs a 1-bit counter; it simply never advances.
  localparam int                 c_CNT_W = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_TICKS);
  localparam bit                 c_TO_EN = (TIMEOUT_TICKS > 0);

  logic [2:0]            r_state, w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_op_a, w_op_a_nxt;
  logic [DATA_WIDTH-1:0] r_op_b, w_op_b_nxt;
  logic [OP_WIDTH-1:0]   r_opcode, w_opcode_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nxt;
  logic                  r_tx_start, w_tx_start_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_timeout_err;
  logic                  w_in_window;
  logic                  w_timeout;

  assign w_in_window = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);
  // A byte arriving on the limit cycle wins over the timeout.
  assign w_timeout   = c_TO_EN && w_in_window && !rx_done && (r_cnt == c_LIMIT);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state       <= S_WAIT_A;
      r_cnt         <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_opcode      <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_op_a        <= w_op_a_nxt;
      r_op_b        <= w_op_b_nxt;
      r_opcode      <= w_opcode_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_timeout;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_A:  if (rx_done) w_state_nxt = S_WAIT_B;
      S_WAIT_B:  if (rx_done) w_state_nxt = S_WAIT_OP;
                 else if (w_timeout) w_state_nxt = S_WAIT_A;
      S_WAIT_OP: if (rx_done) w_state_nxt = S_EXEC;
                 else if (w_timeout) w_state_nxt = S_WAIT_A;
      S_EXEC:    w_state_nxt = S_SEND;
      S_SEND:    w_state_nxt = S_WAIT_TX;
      S_WAIT_TX: if (tx_done) w_state_nxt = S_WAIT_A;
      default:   w_state_nxt = S_WAIT_A;
    endcase
  end

  always_comb begin
    w_op_a_nxt     = r_op_a;
    w_op_b_nxt     = r_op_b;
    w_opcode_nxt   = r_opcode;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    w_cnt_nxt      = '0;
    case (r_state)
      S_WAIT_A:  if (rx_done) w_op_a_nxt = rx_data;
      S_WAIT_B:  if (rx_done) w_op_b_nxt = rx_data;
      S_WAIT_OP: if (rx_done) w_opcode_nxt = rx_data[OP_WIDTH-1:0];
      S_EXEC: begin
        w_tx_data_nxt  = alu_result;
        w_tx_start_nxt = 1'b1;
      end
      default: ;
    endcase
    // Saturating tick count while waiting for the next byte of a command.
    if (w_in_window && !rx_done && !w_timeout)
      w_cnt_nxt = (TICK && (r_cnt != c_LIMIT)) ? r_cnt + 1'b1 : r_cnt;
    w_busy_nxt = (w_state_nxt != S_WAIT_A);
  end

  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign opcode      = r_opcode;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_uart_alu_sequencer: two instances (timeout 4 and disabled) against  |
// | a command-level reference model.   Revision: 1.0                       |
// +------------------------------------------------------------------------+
module tb_uart_alu_sequencer;

  logic       CLK;
  logic       reset;
  logic       TICK;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_done;

  logic [7:0] alu_r[2];
  logic [7:0] op_a[2];
  logic [7:0] op_b[2];
  logic [5:0] opcode[2];
  logic [7:0] tx_data[2];
  logic       tx_start[2];
  logic       busy[2];
  logic       timeout_err[2];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    return (op == 6'h20) ? a + b : a ^ b;
  endfunction

  assign alu_r[0] = alu_f(op_a[0], op_b[0], opcode[0]);
  assign alu_r[1] = alu_f(op_a[1], op_b[1], opcode[1]);

  uart_alu_sequencer #(.DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT_TICKS(4)) dut4 (
    .CLK(CLK), .reset(reset), .TICK(TICK), .rx_done(rx_done), .rx_data(rx_data),
    .tx_done(tx_done), .alu_result(alu_r[0]), .op_a(op_a[0]), .op_b(op_b[0]),
    .opcode(opcode[0]), .tx_data(tx_data[0]), .tx_start(tx_start[0]),
    .busy(busy[0]), .timeout_err(timeout_err[0]));

  uart_alu_sequencer #(.DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT_TICKS(0)) dut0 (
    .CLK(CLK), .reset(reset), .TICK(TICK), .rx_done(rx_done), .rx_data(rx_data),
    .tx_done(tx_done), .alu_result(alu_r[1]), .op_a(op_a[1]), .op_b(op_b[1]),
    .opcode(opcode[1]), .tx_data(tx_data[1]), .tx_start(tx_start[1]),
    .busy(busy[1]), .timeout_err(timeout_err[1]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: 'held' = bytes of the current command in hand (0..2); 3 = result
  // due, 4 = start pulse showing, 5 = waiting for the transmitter.
  int         lim[2] = '{4, 0};
  int         held[2];
  int         ticks[2];
  logic [7:0] ea[2], eb[2], etx[2];
  logic [5:0] eop[2];
  logic       ets[2], ebusy[2], eterr[2];

  task automatic model_step(input int i);
    if (reset) begin
      held[i] = 0; ticks[i] = 0; ea[i] = 0; eb[i] = 0; eop[i] = 0;
      etx[i] = 0; ets[i] = 0; eterr[i] = 0;
    end else begin
      ets[i] = 0;
      eterr[i] = 0;
      case (held[i])
        0: if (rx_done) begin ea[i] = rx_data; held[i] = 1; ticks[i] = 0; end
        1, 2: begin
          if (rx_done) begin
            if (held[i] == 1) eb[i] = rx_data; else eop[i] = rx_data[5:0];
            held[i] = held[i] + 1;
            ticks[i] = 0;
          end else if (lim[i] > 0 && ticks[i] == lim[i]) begin
            held[i] = 0; eterr[i] = 1; ticks[i] = 0;
          end else if (TICK && ticks[i] < lim[i]) begin
            ticks[i] = ticks[i] + 1;
          end
        end
        3: begin etx[i] = alu_f(ea[i], eb[i], eop[i]); ets[i] = 1; held[i] = 4; end
        4: held[i] = 5;
        default: if (tx_done) held[i] = 0;
      endcase
    end
    ebusy[i] = !reset && (held[i] != 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_op_a", i), 32'(op_a[i]), 32'(ea[i]));
      chk($sformatf("d%0d_op_b", i), 32'(op_b[i]), 32'(eb[i]));
      chk($sformatf("d%0d_opcode", i), 32'(opcode[i]), 32'(eop[i]));
      chk($sformatf("d%0d_tx_data", i), 32'(tx_data[i]), 32'(etx[i]));
      chk($sformatf("d%0d_tx_start", i), 32'(tx_start[i]), 32'(ets[i]));
      chk($sformatf("d%0d_busy", i), 32'(busy[i]), 32'(ebusy[i]));
      chk($sformatf("d%0d_timeout_err", i), 32'(timeout_err[i]), 32'(eterr[i]));
    end
  endtask

  task automatic cycle(input bit rst_i, input bit rx_i, input logic [7:0] d_i,
                       input bit tk_i, input bit txd_i);
    reset = rst_i; rx_done = rx_i; rx_data = d_i; TICK = tk_i; tx_done = txd_i;
    @(posedge CLK);
    model_step(0);
    model_step(1);
    @(negedge CLK);
    check_all();
  endtask

  task automatic do_reset();
    cycle(1, 0, 8'h00, 0, 0);
  endtask

  task automatic send(input logic [7:0] d);
    cycle(0, 1, d, 0, 0);
  endtask

  task automatic idle(input int n, input bit tk);
    for (int k = 0; k < n; k++) cycle(0, 0, 8'h00, tk, 0);
  endtask

  task automatic finish_tx();
    cycle(0, 0, 8'h00, 0, 1);
  endtask

  initial begin
    do_reset();
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_tx_data", 32'(tx_data[0]), 32'd0);

    // Basic command: 5 + 3
    send(8'h05); send(8'h03); send(8'h20);
    idle(1, 0);
    chk("t1_tx_start", 32'(tx_start[0]), 32'd1);
    chk("t1_tx_data", 32'(tx_data[0]), 32'h08);
    idle(3, 0);
    chk("t1_busy_hold", 32'(busy[0]), 32'd1);
    finish_tx();
    chk("t1_busy_done", 32'(busy[0]), 32'd0);

    // Timeout after four ticks with no second byte
    do_reset();
    send(8'h11); idle(4, 1); idle(1, 0);
    chk("t2_timeout_err", 32'(timeout_err[0]), 32'd1);
    chk("t2_idle", 32'(busy[0]), 32'd0);
    do_reset();
    send(8'h02); send(8'h02); send(8'h20); idle(2, 0);
    chk("t2_tx_data", 32'(tx_data[0]), 32'h04);
    finish_tx();

    // Byte coinciding with the limiting tick is accepted
    do_reset();
    send(8'h11); idle(3, 1);
    cycle(0, 1, 8'h22, 1, 0);
    idle(1, 1);
    chk("t3_op_b", 32'(op_b[0]), 32'h22);
    chk("t3_no_timeout", 32'(timeout_err[0]), 32'd0);

    // Stray byte while waiting for transmitter
    do_reset();
    send(8'h0A); send(8'h0B); send(8'h01); idle(3, 0);
    send(8'hFF);
    finish_tx();
    chk("t4_op_a_kept", 32'(op_a[0]), 32'h0A);
    send(8'h33);
    chk("t4_next_a", 32'(op_a[0]), 32'h33);

    // Reset in WAIT_OP, then in the EXEC cycle
    do_reset();
    send(8'h44); send(8'h55); do_reset();
    chk("t5_reset_wop", 32'(op_a[0]), 32'd0);
    send(8'h44); send(8'h55); send(8'h20); do_reset();
    chk("t5_no_start", 32'(tx_start[0]), 32'd0);
    idle(3, 0);

    // Disabled timeout survives a long gap
    do_reset();
    send(8'h07); idle(10000, 1); send(8'h09); send(8'h20); idle(2, 0);
    chk("t6_tx_data", 32'(tx_data[1]), 32'h10);
    finish_tx();

    // Random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
            8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
